// File: rtl/mult_booth16_sequencer.sv
// Radix-16 Booth multiplier sequencer: one Booth digit per cycle into a 2*WIDTH accumulator.
// Latency: Done rises WIDTH/4 (signed) or WIDTH/4+1 (unsigned) cycles after the accepting edge.
// Backpressure: none; Start is ignored while Busy, Abort cancels RUN or blocks Start when idle.
module mult_booth16_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             Start,
    input  logic             Signed,
    input  logic             Abort,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [4:0]       DigitSel,
    output logic [3:0]       StepIdx
);

    localparam int PW      = 2 * WIDTH;
    localparam int BXW     = WIDTH + 5;
    localparam int SW      = $clog2(BXW);
    localparam int NSTEP_S = WIDTH / 4;
    localparam int NSTEP_U = WIDTH / 4 + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            load;
    logic            step;
    logic            commit;

    logic [PW-1:0]   aext;
    logic [BXW-1:0]  bx;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic [PW-1:0]   hilo;
    logic [3:0]      k;
    logic [3:0]      nlast;

    logic [SW-1:0]   base;
    logic [4:0]      w;
    logic [3:0]      p;
    logic [3:0]      mag;
    logic [PW-1:0]   mult;
    logic [PW-1:0]   pp;

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        commit    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start && !Abort) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                // Abort wins even on the final step so a cancelled op never lands in Hi/Lo.
                if (Abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (k == nlast) begin
                        commit    = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Booth window for digit k: {b[4k+3:4k], b[4k-1]}, with the implicit b[-1]=0 at bx[0].
    always_comb begin
        base = SW'({k, 2'b00});
        w    = bx[base +: 5];
    end

    // d = p - 8*w[4] with p in 0..8, so |d| is p or 8-p and the sign is w[4].
    always_comb begin
        p   = {1'b0, w[3], w[2], w[1]} + {3'b000, w[0]};
        mag = w[4] ? (4'd8 - p) : p;
        case (mag)
            4'd0:    mult = '0;
            4'd1:    mult = aext;
            4'd2:    mult = aext << 1;
            4'd3:    mult = aext + (aext << 1);
            4'd4:    mult = aext << 2;
            4'd5:    mult = aext + (aext << 2);
            4'd6:    mult = (aext << 1) + (aext << 2);
            4'd7:    mult = (aext << 3) - aext;
            4'd8:    mult = aext << 3;
            default: mult = '0;
        endcase
        pp      = w[4] ? (~mult + 1'b1) : mult;
        acc_nxt = acc + (pp << {k, 2'b00});
    end

    always_ff @(posedge CLK or negedge Clear) begin
        if (!Clear) begin
            aext  <= '0;
            bx    <= '0;
            acc   <= '0;
            k     <= '0;
            nlast <= '0;
            hilo  <= '0;
        end else begin
            if (load) begin
                aext  <= Signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
                bx    <= {{4{Signed & B[WIDTH-1]}}, B, 1'b0};
                acc   <= '0;
                k     <= '0;
                nlast <= Signed ? 4'(NSTEP_S - 1) : 4'(NSTEP_U - 1);
            end else if (step) begin
                acc <= acc_nxt;
                k   <= k + 4'd1;
            end
            if (commit) begin
                hilo <= acc_nxt;
            end
        end
    end

    always_comb begin
        Busy     = (state == S_RUN);
        Done     = (state == S_DONE);
        Hi       = hilo[PW-1:WIDTH];
        Lo       = hilo[WIDTH-1:0];
        DigitSel = Busy ? w : 5'd0;
        StepIdx  = Busy ? k : 4'd0;
    end

endmodule

// File: tb/tb_mult_booth16_sequencer.sv
// Scoreboard bench for mult_booth16_sequencer: expected products queued at launch, compared on Done.
module tb_mult_booth16_sequencer;

    logic        CLK;
    logic        Clear;
    logic        Start;
    logic        Signed;
    logic        Abort;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [4:0]  DigitSel;
    logic [3:0]  StepIdx;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];

    mult_booth16_sequencer #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .Clear    (Clear),
        .Start    (Start),
        .Signed   (Signed),
        .Abort    (Abort),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .Hi       (Hi),
        .Lo       (Lo),
        .DigitSel (DigitSel),
        .StepIdx  (StepIdx)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge CLK);
        Start  = 1'b1;
        Signed = s;
        A      = a;
        B      = b;
        if (push) exp_q.push_back(model(s, a, b));
        @(negedge CLK);
        Start = 1'b0;
    endtask

    // Called one negedge after the accepting edge; returns at the negedge where Done is seen.
    task automatic wait_done(input string tag, input int exp_lat, output logic [4:0] last_dsel);
        int cyc;
        int stp;
        bit seen;
        cyc = 1;
        stp = 0;
        seen = 1'b0;
        last_dsel = 5'd0;
        while (cyc <= 40) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            if (Busy) begin
                check_eq({tag, "_stepidx"}, 64'(StepIdx), 64'(stp));
                last_dsel = DigitSel;
                stp++;
            end
            @(negedge CLK);
            cyc++;
        end
        if (!seen) check_eq({tag, "_timeout"}, 64'(Done), 64'd1);
        else       check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    endtask

    // Every Done must retire exactly one queued expectation.
    initial begin
        forever begin
            @(negedge CLK);
            if (Clear && Done) begin
                if (exp_q.size() == 0) check_eq("spurious_done", 64'(Done), 64'd0);
                else                   check_eq("result", {Hi, Lo}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [4:0]  ds;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          n;

        Clear = 1'b1; Start = 1'b0; Signed = 1'b0; Abort = 1'b0; A = '0; B = '0;
        #2 Clear = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_busy", 64'(Busy), 64'd0);
        check_eq("rst_done", 64'(Done), 64'd0);
        check_eq("rst_hilo", {Hi, Lo}, 64'd0);
        check_eq("rst_dsel", 64'(DigitSel), 64'd0);
        check_eq("rst_step", 64'(StepIdx), 64'd0);
        Clear = 1'b1;

        // T1
        launch(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1);
        wait_done("t1", 9, ds);
        check_eq("t1_value", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // T2
        launch(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("t2", 9, ds);
        check_eq("t2_value", {Hi, Lo}, 64'h4000_0000_0000_0000);
        check_eq("t2_last_dsel", 64'(ds), 64'h10);

        // T3
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("t3", 10, ds);
        check_eq("t3_value", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);

        // T4: establish 0x1_00000002, then abort a new op at StepIdx=3
        launch(1'b0, 32'd2, 32'h8000_0001, 1'b1);
        wait_done("t4pre", 10, ds);
        launch(1'b1, 32'h1234, 32'h5678, 1'b0);
        n = 0;
        while (StepIdx != 4'd3 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq("t4_reach_step3", 64'(StepIdx), 64'd3);
        Abort = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        check_eq("t4_busy", 64'(Busy), 64'd0);
        check_eq("t4_done", 64'(Done), 64'd0);
        check_eq("t4_hi", 64'(Hi), 64'd1);
        check_eq("t4_lo", 64'(Lo), 64'd2);
        repeat (12) @(negedge CLK);
        check_eq("t4_hold", {Hi, Lo}, 64'h1_0000_0002);

        // Abort while idle blocks Start
        @(negedge CLK);
        Start = 1'b1; Abort = 1'b1; Signed = 1'b1; A = 32'd9; B = 32'd9;
        @(negedge CLK);
        Start = 1'b0; Abort = 1'b0;
        check_eq("abort_idle_busy", 64'(Busy), 64'd0);
        repeat (12) @(negedge CLK);

        // T5: Start while busy is ignored
        launch(1'b1, 32'h0001_2345, 32'hFFFF_FFB3, 1'b1);
        repeat (2) @(negedge CLK);
        Start = 1'b1; Signed = 1'b0; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge CLK);
        Start = 1'b0;
        n = 0;
        while (!Done && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check_eq("t5_latency", 64'(n), 64'd5);
        // Clear mid-run wipes state immediately
        launch(1'b1, 32'd100, 32'd200, 1'b1);
        repeat (3) @(negedge CLK);
        Clear = 1'b0;
        #1;
        check_eq("t5_clr_busy", 64'(Busy), 64'd0);
        check_eq("t5_clr_hi", 64'(Hi), 64'd0);
        check_eq("t5_clr_lo", 64'(Lo), 64'd0);
        exp_q.delete();
        @(negedge CLK);
        Clear = 1'b1;

        // T6: back-to-back launch in the Done cycle
        launch(1'b1, 32'hFFFF_FFFB, 32'd9, 1'b1);
        wait_done("t6a", 9, ds);
        Start = 1'b1; Signed = 1'b1; A = 32'd3; B = 32'd5;
        exp_q.push_back(model(1'b1, 32'd3, 32'd5));
        @(negedge CLK);
        Start = 1'b0;
        check_eq("t6_busy", 64'(Busy), 64'd1);
        wait_done("t6b", 9, ds);
        check_eq("t6_lo", 64'(Lo), 64'd15);
        check_eq("t6_hi", 64'(Hi), 64'd0);

        // Random operands, both modes
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            launch(rs, ra, rb, 1'b1);
            wait_done("rand", rs ? 9 : 10, ds);
        end

        repeat (2) @(negedge CLK);
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
